// File: rtl/rows_writer.sv
// Writes a captured block of N_ROWS rows to the row RAM at consecutive addresses, one per cycle.
// Optional build macro ROWS_WRITER_SKIP_ZERO_EN suppresses the write strobe for all-zero rows.
module rows_writer #(
    parameter int unsigned N_ROWS = 4,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_ROWS*WIDTH-1:0]   in_rows,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [WIDTH-1:0]          mem_data_in,
    output logic                      mem_write_enable,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned KW = $clog2(N_ROWS + 1);
    localparam logic [KW-1:0] K_LAST = KW'(N_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [N_ROWS*WIDTH-1:0]  rows_q, rows_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]         mem_data_q, mem_data_d;
    logic                     mem_we_q, mem_we_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [KW-1:0]            k_next;
    logic [WIDTH-1:0]         next_row;
    logic                     first_we;
    logic                     next_we;

    always_comb begin
        k_next   = k_q + 1'b1;
        next_row = '0;
        for (int unsigned i = 0; i < N_ROWS; i++) begin
            if (KW'(i) == k_next) begin
                next_row = rows_q[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef ROWS_WRITER_SKIP_ZERO_EN
    assign first_we = |in_rows[WIDTH-1:0];
    assign next_we  = |next_row;
`else
    assign first_we = 1'b1;
    assign next_we  = 1'b1;
`endif

    // Outputs are registered, so row 0 is loaded straight from the inputs at the accept edge
    // and each WRITE edge loads the slot after the one currently on the bus.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        rows_d     = rows_q;
        base_d     = base_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d    = S_WRITE;
                    k_d        = '0;
                    rows_d     = in_rows;
                    base_d     = base_addr;
                    mem_addr_d = base_addr;
                    mem_data_d = in_rows[WIDTH-1:0];
                    mem_we_d   = first_we;
                    busy_d     = 1'b1;
                end
            end
            S_WRITE: begin
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    k_d        = k_next;
                    mem_addr_d = base_q + ADDR_W'(k_next);
                    mem_data_d = next_row;
                    mem_we_d   = next_we;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            rows_q     <= '0;
            base_q     <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            rows_q     <= rows_d;
            base_q     <= base_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready         = (state_q == S_IDLE);
    assign mem_addr         = mem_addr_q;
    assign mem_data_in      = mem_data_q;
    assign mem_write_enable = mem_we_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: doc/rows_writer.md
Name: rows_writer

Overview:
Writes back a packed block of N_ROWS rows into the single-port row RAM, one row per cycle, at consecutive addresses starting from a base address. It is the write-side counterpart of the row-gathering path: a producer hands over a full row block with a valid/ready handshake, and this block drives the RAM's addr, data_in and write_enable. It reports completion with a one-cycle done pulse.

Parameters:
N_ROWS, 4, number of rows per block; must be at least 1.
WIDTH, 32, bits per row and RAM data width.
ADDR_W, 4, RAM address width.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
in_rows  input  N_ROWS*WIDTH  packed rows; row i occupies bits [i*WIDTH +: WIDTH].
base_addr  input  ADDR_W  RAM address for row 0; sampled at handshake.
in_valid  input  1  producer has a block on in_rows/base_addr.
in_ready  output  1  block can accept a new block; high only in IDLE.
mem_addr  output  ADDR_W  RAM address.
mem_data_in  output  WIDTH  RAM write data.
mem_write_enable  output  1  RAM write strobe.
busy  output  1  block is in WRITE or DONE.
done  output  1  one-cycle pulse after the last row slot.

Behaviour:
- Reset: rst sampled high at a clock edge; rst has priority over every other event.
  - State goes to IDLE.
  - Row counter goes to 0.
  - mem_addr=0, mem_data_in=0, mem_write_enable=0, busy=0, done=0, in_ready=1 (from the cycle after the reset edge).
- All outputs are registered except in_ready, which is decoded from state (IDLE -> 1).
- States:
  - IDLE: waits for a handshake.
  - WRITE: issues one row per cycle.
  - DONE: single cycle; signals completion.
- Handshake: accept occurs at an edge where in_valid && in_ready.
  - Capture in_rows into an internal buffer and base_addr into an address register.
  - Clear the row counter k to 0.
  - Go to WRITE.
  - in_valid while in_ready=0 is ignored; the producer must hold the block.
- Timing for an accept at edge T:
  - Cycles T+1 .. T+N_ROWS: mem_write_enable=1, mem_addr=base+k, mem_data_in=row k, for k = 0 .. N_ROWS-1.
  - Cycle T+N_ROWS+1: DONE state; done=1, mem_write_enable=0.
  - Cycle T+N_ROWS+2: IDLE; in_ready=1. This is the earliest cycle a next accept can occur.
  - busy=1 from T+1 through T+N_ROWS+1 inclusive.
- Address arithmetic: base+k is computed modulo 2^ADDR_W and wraps silently. Example: base=14, N_ROWS=4 gives 14, 15, 0, 1.
- Row counter width is $clog2(N_ROWS+1) bits.
  - WRITE -> DONE when k == N_ROWS-1 at the edge.
  - N_ROWS=1 gives exactly one write cycle.
- Outside WRITE: mem_data_in and mem_addr hold their last values; mem_write_enable=0.
- Captured data is immune to in_rows/base_addr changes after the accept.
- Reset during WRITE or DONE:
  - The block is aborted.
  - mem_write_enable=0 on the next cycle.
  - No further writes and no done pulse.

Optional Feature:
ROWS_WRITER_SKIP_ZERO_EN
- Defined: in WRITE, a row whose captured value is all zeros is not written.
  - mem_write_enable=0 for that slot.
  - mem_addr and mem_data_in are still driven as usual and k still advances.
  - Cycle count and done timing are unchanged.
- Undefined: every row is written, including zero rows.

Test Plan:
1. Reset then idle: hold rst=1 for 2 cycles, then release -> in_ready=1; busy, done, mem_write_enable, mem_addr, mem_data_in all 0.
2. Basic block: base_addr=2, rows {0x11,0x22,0x33,0x44}, in_valid pulse at edge T -> writes (2,0x11) (3,0x22) (4,0x33) (5,0x44) at T+1..T+4; done=1 at T+5 only; in_ready=1 at T+6.
3. Wrap-around: base_addr=14, rows {A,B,C,D} -> addresses 14, 15, 0, 1 with data A, B, C, D.
4. Back-pressure and data stability: hold in_valid=1 with block X, then change in_rows to block Y during WRITE -> X is written unchanged; Y is accepted at T+6 and written at T+7..T+10; no handshake during busy.
5. Reset mid-operation: assert rst in the cycle of the second write -> mem_write_enable=0 from the next cycle; no done pulse; in_ready=1; a new block afterwards writes normally.
6. Zero rows: rows {0,0x5,0,0x7} at base 0.
   - ROWS_WRITER_SKIP_ZERO_EN undefined: 4 writes.
   - ROWS_WRITER_SKIP_ZERO_EN defined: write_enable only at addresses 1 and 3.
   - In both builds, done appears at T+5.
